// File: rtl/ooc_harness_pkg.sv
// Shared types and constants for the out-of-context stream harness.
// Holds the FSM encoding, LFSR polynomials, the word-mixing constant
// and the digest fold used to squeeze a wide digest into the signature.
package ooc_harness_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_OUT = 2'd2,
        ST_GAP      = 2'd3
    } state_t;

    localparam logic [31:0] DATA_POLY = 32'h8020_0003;
    localparam logic [15:0] CTRL_POLY = 16'hB400;
    localparam logic [31:0] DATA_MIX  = 32'h9E37_79B9;

    // Upper bounds for the fold operands; callers zero-extend into / truncate out of these.
    localparam int FOLD_MAX_IN  = 4096;
    localparam int FOLD_MAX_SIG = 256;

    // XOR of all sig_w-bit slices of the low out_w bits of d.
    function automatic logic [FOLD_MAX_SIG-1:0] fold(
        input logic [FOLD_MAX_IN-1:0] d,
        input int                     out_w,
        input int                     sig_w
    );
        logic [FOLD_MAX_SIG-1:0] acc;
        logic [7:0]              bit_idx;
        logic [11:0]             in_idx;
        acc = '0;
        for (int i = 0; i < FOLD_MAX_IN; i++) begin
            if (i < out_w) begin
                bit_idx      = 8'(i % sig_w);
                in_idx       = 12'(i);
                acc[bit_idx] = acc[bit_idx] ^ d[in_idx];
            end
        end
        return acc;
    endfunction

endpackage

// File: rtl/lfsr_galois.sv
// Right-shifting Galois LFSR with seed reload on reset.
// Latency: new state visible the cycle after advance is sampled high.
// Backpressure: state holds whenever advance is low.
module lfsr_galois #(
    parameter int               WIDTH = 32,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(1),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    output logic [WIDTH-1:0] state
);

    // Shift right, folding the polynomial in when the outgoing bit is set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SEED;
        end else if (advance) begin
            state <= (state >> 1) ^ (state[0] ? POLY : '0);
        end
    end

endmodule

// File: rtl/ooc_stream_harness.sv
// Random stimulus source and MISR response sink around a streaming hash/cipher core.
// Latency: first word the cycle after enable is seen in IDLE; signature updates one cycle after digest-valid rises.
// Backpressure: dut_buffer_full freezes the word, word count and data LFSR; the control LFSR keeps running.
module ooc_stream_harness
    import ooc_harness_pkg::*;
#(
    parameter int          IN_WIDTH   = 32,
    parameter int          OUT_WIDTH  = 512,
    parameter int          SIG_WIDTH  = 32,
    parameter int          MSG_WORDS  = 4,
    parameter logic [31:0] DATA_SEED  = 32'h0000_0001,
    parameter logic [15:0] CTRL_SEED  = 16'hACE1,
    parameter bit          STALL_EN   = 1'b1,
    parameter int          GAP_CYCLES = 8,
    parameter int          TIMEOUT    = 1024,
    localparam int         BN         = $clog2(IN_WIDTH / 8)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    output logic [IN_WIDTH-1:0]  dut_in,
    output logic                 dut_in_ready,
    output logic                 dut_is_last,
    output logic [BN-1:0]        dut_byte_num,
    input  logic                 dut_buffer_full,
    input  logic [OUT_WIDTH-1:0] dut_out,
    input  logic                 dut_out_ready,
    output logic [SIG_WIDTH-1:0] signature,
    output logic [15:0]          msg_count,
    output logic                 timeout_err,
    output logic                 busy
);

    localparam int WW   = (MSG_WORDS > 1) ? $clog2(MSG_WORDS) : 1;
    localparam int MAXC = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_busy;
    logic [WW-1:0]        r_word_cnt;
    logic [CW-1:0]        r_cnt;
    logic [BN-1:0]        r_byte_num;
    logic                 r_out_rdy_q;
    logic [SIG_WIDTH-1:0] r_signature;
    logic [15:0]          r_msg_count;
    logic                 r_timeout_err;

    logic [31:0]          w_data_s;
    logic [15:0]          w_ctrl_s;
    logic                 w_pace_ok;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_rise;
    logic                 w_tmo;
    logic                 w_gap_done;
    logic                 w_start;
    logic [SIG_WIDTH-1:0] w_fold;

    // Data LFSR steps only on accepted words, so a stalled word is re-presented unchanged.
    lfsr_galois #(.WIDTH(32), .POLY(DATA_POLY), .SEED(DATA_SEED)) u_data_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (w_accept),
        .state   (w_data_s)
    );

    // Control LFSR free-runs and supplies pacing and byte_num randomness.
    lfsr_galois #(.WIDTH(16), .POLY(CTRL_POLY), .SEED(CTRL_SEED)) u_ctrl_lfsr (
        .clk     (clk),
        .reset   (reset),
        .advance (1'b1),
        .state   (w_ctrl_s)
    );

    // Wider words are built from decorrelated copies of the 32-bit LFSR state.
    for (genvar k = 0; k < IN_WIDTH / 32; k++) begin : g_word
        assign dut_in[32*k +: 32] = w_data_s ^ (32'(k) * DATA_MIX);
    end

    assign w_pace_ok    = ~STALL_EN | w_ctrl_s[0];
    assign w_last       = (r_word_cnt == WW'(MSG_WORDS - 1));
    assign dut_in_ready = (r_state == ST_SEND) & ~dut_buffer_full & w_pace_ok;
    assign dut_is_last  = (r_state == ST_SEND) & w_last;
    assign w_accept     = dut_in_ready;
    assign w_rise       = dut_out_ready & ~r_out_rdy_q;
    assign w_tmo        = (r_cnt == CW'(TIMEOUT - 1));
    assign w_gap_done   = (r_cnt == CW'(GAP_CYCLES - 1));
    assign w_start      = (w_state_nxt == ST_SEND) && (r_state != ST_SEND);
    assign w_fold       = SIG_WIDTH'(fold(FOLD_MAX_IN'(dut_out), OUT_WIDTH, SIG_WIDTH));

    assign dut_byte_num = r_byte_num;
    assign signature    = r_signature;
    assign msg_count    = r_msg_count;
    assign timeout_err  = r_timeout_err;
    assign busy         = r_busy;

    // Next-state decode; enable only matters at message boundaries.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:     if (enable) w_state_nxt = ST_SEND;
            ST_SEND:     if (w_accept && w_last) w_state_nxt = ST_WAIT_OUT;
            ST_WAIT_OUT: if (w_rise || w_tmo) w_state_nxt = ST_GAP;
            ST_GAP:      if (w_gap_done) w_state_nxt = enable ? ST_SEND : ST_IDLE;
            default:     w_state_nxt = ST_IDLE;
        endcase
    end

    // State register, with busy registered from the next state so it tracks the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
        end
    end

    // Word position, byte_num draw and a shared timeout/gap counter cleared on every state change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_word_cnt <= '0;
            r_byte_num <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_start) begin
                r_word_cnt <= '0;
                r_byte_num <= w_ctrl_s[BN-1:0];
            end else if (w_accept) begin
                r_word_cnt <= r_word_cnt + WW'(1);
            end
            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state == ST_WAIT_OUT || r_state == ST_GAP) begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    // Digest capture into the MISR on a digest-valid rising edge; sticky flag if it never comes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_rdy_q   <= 1'b0;
            r_signature   <= '0;
            r_msg_count   <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_out_rdy_q <= dut_out_ready;
            if (r_state == ST_WAIT_OUT) begin
                if (w_rise) begin
                    r_signature <= {r_signature[SIG_WIDTH-2:0], r_signature[SIG_WIDTH-1]} ^ w_fold;
                    r_msg_count <= r_msg_count + 16'd1;
                end else if (w_tmo) begin
                    r_timeout_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ooc_stream_harness.sv
// Directed-plus-random bench for ooc_stream_harness with a message-level reference model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// The model tracks the data word sequence, byte_num draws, MISR signature and counters.
module tb_ooc_stream_harness;

    localparam int OW  = 512;
    localparam int MW  = 4;
    localparam int GAP = 8;
    localparam int TMO = 64;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [31:0]   dut_in;
    logic          dut_in_ready;
    logic          dut_is_last;
    logic [1:0]    dut_byte_num;
    logic          dut_buffer_full;
    logic [OW-1:0] dut_out;
    logic          dut_out_ready;
    logic [31:0]   signature;
    logic [15:0]   msg_count;
    logic          timeout_err;
    logic          busy;

    int            checks = 0;
    int            errors = 0;
    int            edges;
    logic [31:0]   m_lfsr;
    logic [31:0]   m_sig;
    logic [15:0]   m_cnt;
    logic          m_err;
    logic [31:0]   known_words [3];

    ooc_stream_harness #(
        .IN_WIDTH(32), .OUT_WIDTH(OW), .SIG_WIDTH(32), .MSG_WORDS(MW),
        .DATA_SEED(32'h0000_0001), .CTRL_SEED(16'hACE1), .STALL_EN(1'b0),
        .GAP_CYCLES(GAP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dut_in(dut_in), .dut_in_ready(dut_in_ready), .dut_is_last(dut_is_last),
        .dut_byte_num(dut_byte_num), .dut_buffer_full(dut_buffer_full),
        .dut_out(dut_out), .dut_out_ready(dut_out_ready),
        .signature(signature), .msg_count(msg_count),
        .timeout_err(timeout_err), .busy(busy)
    );

    always #5 clk = ~clk;

    // Clock edges since reset release: the control LFSR has advanced exactly this many times.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    function automatic logic [31:0] data_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    function automatic logic [15:0] ctrl_after(input int n);
        logic [15:0] s;
        s = 16'hACE1;
        for (int i = 0; i < n; i++) s = (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0);
        return s;
    endfunction

    function automatic logic [31:0] fold_ref(input logic [OW-1:0] d);
        logic [31:0] acc;
        acc = 32'h0;
        for (int s = 0; s < OW / 32; s++) acc = acc ^ d[32*s +: 32];
        return acc;
    endfunction

    function automatic logic [OW-1:0] rand_digest();
        logic [OW-1:0] d;
        for (int s = 0; s < OW / 32; s++) d[32*s +: 32] = $urandom;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_in"}, dut_in, 32'h0000_0001);
        chk({tag, "_rdy"}, dut_in_ready, 1'b0);
        chk({tag, "_last"}, dut_is_last, 1'b0);
        chk({tag, "_bn"}, dut_byte_num, 2'b00);
        chk({tag, "_sig"}, signature, 32'h0);
        chk({tag, "_cnt"}, msg_count, 16'h0);
        chk({tag, "_err"}, timeout_err, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    // Called on the first SEND cycle; mode 0 = no backpressure, 1 = full for 10 cycles after word 1, 2 = random.
    task automatic send_msg(input int mode, input int stop_after, input bit drop_en, input bit const_chk);
        int          n;
        int          cyc;
        int          held;
        logic        f;
        logic [15:0] c;
        n    = 0;
        cyc  = 0;
        held = 0;
        c    = ctrl_after(edges - 1);
        while (n < stop_after && cyc < 400) begin
            case (mode)
                0:       f = 1'b0;
                1:       f = (n == 1) && (held < 10);
                default: f = ($urandom_range(0, 2) == 0);
            endcase
            if (mode == 1 && f) held++;
            dut_buffer_full = f;
            if (drop_en && n == 1) enable = 1'b0;
            mid();
            chk("in_ready", dut_in_ready, !f);
            chk("in_data", dut_in, m_lfsr);
            if (const_chk && n < 3) chk("in_const", dut_in, known_words[n]);
            chk("is_last", dut_is_last, (n == MW - 1));
            chk("byte_num", dut_byte_num, c[1:0]);
            chk("busy_send", busy, 1'b1);
            if (!f) begin
                n++;
                m_lfsr = data_next(m_lfsr);
            end
            cyc++;
            tick();
        end
        dut_buffer_full = 1'b0;
        chk("send_budget", (cyc < 400), 1'b1);
    endtask

    task automatic wait_digest(input logic [OW-1:0] dig, input int delay);
        for (int j = 0; j < delay; j++) begin
            dut_out_ready = 1'b0;
            dut_out       = rand_digest();
            mid();
            chk("wait_busy", busy, 1'b1);
            chk("wait_rdy", dut_in_ready, 1'b0);
            chk("wait_cnt", msg_count, m_cnt);
            chk("wait_err", timeout_err, m_err);
            tick();
        end
        dut_out       = dig;
        dut_out_ready = 1'b1;
        mid();
        chk("pulse_sig", signature, m_sig);
        tick();
        m_sig = {m_sig[30:0], m_sig[31]} ^ fold_ref(dig);
        m_cnt = m_cnt + 16'd1;
        dut_out_ready = 1'b0;
    endtask

    task automatic timeout_phase();
        for (int j = 0; j < TMO; j++) begin
            dut_out_ready = 1'b0;
            dut_out       = rand_digest();
            mid();
            chk("tmo_err_low", timeout_err, 1'b0);
            chk("tmo_busy", busy, 1'b1);
            tick();
        end
        m_err = 1'b1;
    endtask

    task automatic gap_phase(input bit pulse);
        for (int j = 0; j < GAP; j++) begin
            dut_out_ready = pulse && (j == 3);
            mid();
            chk("gap_sig", signature, m_sig);
            chk("gap_cnt", msg_count, m_cnt);
            chk("gap_err", timeout_err, m_err);
            chk("gap_busy", busy, 1'b1);
            chk("gap_rdy", dut_in_ready, 1'b0);
            chk("gap_in", dut_in, m_lfsr);
            tick();
        end
        dut_out_ready = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        for (int j = 0; j < n; j++) begin
            mid();
            chk("idle_busy", busy, 1'b0);
            chk("idle_rdy", dut_in_ready, 1'b0);
            tick();
        end
    endtask

    initial begin
        logic [OW-1:0] dig;
        known_words[0] = 32'h0000_0001;
        known_words[1] = 32'h8020_0003;
        known_words[2] = 32'hC030_0002;
        m_lfsr = 32'h0000_0001;
        m_sig  = 32'h0;
        m_cnt  = 16'h0;
        m_err  = 1'b0;

        reset           = 1'b1;
        enable          = 1'b0;
        dut_buffer_full = 1'b0;
        dut_out_ready   = 1'b0;
        dut_out         = '0;
        #1;
        chk_reset_vals("rst");
        repeat (3) tick();
        reset = 1'b0;
        idle_cycles(3);

        // First message: back-to-back words with known values, then digest 1 -> signature 1.
        enable = 1'b1;
        mid();
        chk("start_busy", busy, 1'b0);
        tick();
        send_msg(0, MW, 1'b0, 1'b1);
        wait_digest({{(OW-1){1'b0}}, 1'b1}, 3);
        gap_phase(1'b0);
        chk("sig_first", signature, 32'h1);
        chk("cnt_first", msg_count, 16'd1);

        // Second message with a 10-cycle backpressure hold; same digest -> signature 3.
        send_msg(1, MW, 1'b0, 1'b0);
        wait_digest({{(OW-1){1'b0}}, 1'b1}, 0);
        gap_phase(1'b0);
        chk("sig_second", signature, 32'h3);
        chk("cnt_second", msg_count, 16'd2);

        // Random traffic, random digests, stray digest-valid pulses during GAP.
        for (int i = 0; i < 6; i++) begin
            dig = rand_digest();
            send_msg(2, MW, 1'b0, 1'b0);
            wait_digest(dig, $urandom_range(0, 40));
            gap_phase(i % 2 == 1);
        end

        // Digest never arrives: sticky timeout, then traffic resumes after GAP.
        send_msg(2, MW, 1'b0, 1'b0);
        timeout_phase();
        gap_phase(1'b0);
        send_msg(0, MW, 1'b0, 1'b0);
        wait_digest(rand_digest(), 2);
        gap_phase(1'b0);

        // Enable dropped during word 2: message and capture finish, then IDLE.
        send_msg(2, MW, 1'b1, 1'b0);
        wait_digest(rand_digest(), 5);
        gap_phase(1'b0);
        idle_cycles(20);

        // Restart, then assert reset mid-message.
        enable = 1'b1;
        mid();
        chk("restart_busy", busy, 1'b0);
        tick();
        send_msg(0, 2, 1'b0, 1'b0);
        mid();
        chk("pre_rst_rdy", dut_in_ready, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        chk_reset_vals("midrst");
        tick();
        tick();
        chk_reset_vals("midrst_hold");
        reset  = 1'b0;
        m_lfsr = 32'h0000_0001;
        m_sig  = 32'h0;
        m_cnt  = 16'h0;
        m_err  = 1'b0;
        mid();
        chk("post_rst_busy", busy, 1'b0);
        tick();
        dig = rand_digest();
        send_msg(0, MW, 1'b0, 1'b1);
        wait_digest(dig, 1);
        gap_phase(1'b0);
        chk("sig_after_rst", signature, fold_ref(dig));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
